// File: rtl/i2c_slave_regif_pkg.sv
// Shared definitions for the I2C register-interface responder: FSM state encoding,
// byte framing constant, default device address and the address-match helper.
package i2c_slave_regif_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_MACK,
        ST_IGNORE
    } state_t;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h48;
    localparam logic [3:0] BITS_PER_BYTE    = 4'd8;

    function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] dev_addr);
        return addr_byte[7:1] == dev_addr;
    endfunction

endpackage

// File: rtl/i2c_slave_regif_sync_edge.sv
// SCL/SDA input synchronisers with edge detection and START/STOP recognition.
// Resets to a released (high) bus so that coming out of reset never fakes a condition.
module i2c_slave_regif_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda,
    output logic sda_level,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_pipe_reg;
    logic [SYNC_STAGES-1:0] sda_pipe_reg;
    logic                   scl_prev_reg;
    logic                   sda_prev_reg;
    logic                   scl_now;
    logic                   sda_now;

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_pipe_reg <= '1;
            sda_pipe_reg <= '1;
            scl_prev_reg <= 1'b1;
            sda_prev_reg <= 1'b1;
        end else begin
            scl_pipe_reg <= {scl_pipe_reg[SYNC_STAGES-2:0], scl};
            sda_pipe_reg <= {sda_pipe_reg[SYNC_STAGES-2:0], sda};
            scl_prev_reg <= scl_now;
            sda_prev_reg <= sda_now;
        end
    end

    assign scl_now   = scl_pipe_reg[SYNC_STAGES-1];
    assign sda_now   = sda_pipe_reg[SYNC_STAGES-1];
    assign sda_level = sda_now;
    assign scl_rise  = scl_now & ~scl_prev_reg;
    assign scl_fall  = ~scl_now & scl_prev_reg;
    // SDA may only move while SCL is low, so an SDA edge with SCL held high is a bus condition
    assign start_det = scl_now & scl_prev_reg & sda_prev_reg & ~sda_now;
    assign stop_det  = scl_now & scl_prev_reg & ~sda_prev_reg & sda_now;

endmodule

// File: rtl/i2c_slave_regif.sv
// I2C responder turning bus transfers into single-cycle register write/read strobes.
// Define I2C_SLAVE_STRETCH_EN to hold SCL low after each read request until rd_valid.
module i2c_slave_regif
    import i2c_slave_regif_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = DEV_ADDR_DEFAULT,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire        scl,
    inout  wire        sda,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       rd_strobe,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    input  logic       rd_valid,
    output logic       addressed
);

    state_t     state_reg;
    logic [3:0] bc_reg;
    logic [7:0] shift_reg;
    logic [7:0] ptr_reg;
    logic       rw_reg;
    logic       got_ack_reg;
    logic       sda_drive_reg;

    logic sda_level;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic receiving;
    logic byte_done;

`ifdef I2C_SLAVE_STRETCH_EN
    localparam logic [2:0] STRETCH_RELEASE_CLKS = 3'd4;
    logic       scl_drive_reg;
    logic       stretch_wait_reg;
    logic [2:0] stretch_cnt_reg;
`else
    logic unused_rd_valid;
    assign unused_rd_valid = rd_valid;
`endif

    i2c_slave_regif_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk       (clk),
        .reset     (reset),
        .scl       (scl),
        .sda       (sda),
        .sda_level (sda_level),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign receiving = (state_reg == ST_ADDR) || (state_reg == ST_PTR) || (state_reg == ST_WDATA);
    assign byte_done = scl_fall && (bc_reg == BITS_PER_BYTE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            bc_reg        <= '0;
            shift_reg     <= '0;
            ptr_reg       <= '0;
            rw_reg        <= 1'b0;
            got_ack_reg   <= 1'b0;
            sda_drive_reg <= 1'b0;
            wr_strobe     <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            rd_strobe     <= 1'b0;
            rd_addr       <= '0;
            addressed     <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
            scl_drive_reg    <= 1'b0;
            stretch_wait_reg <= 1'b0;
            stretch_cnt_reg  <= '0;
`endif
        end else begin
            wr_strobe <= 1'b0;
            rd_strobe <= 1'b0;
            // Bus conditions take priority over any SCL edge seen in the same cycle; ptr survives both
            if (start_det || stop_det) begin
                state_reg     <= start_det ? ST_ADDR : ST_IDLE;
                bc_reg        <= '0;
                sda_drive_reg <= 1'b0;
                got_ack_reg   <= 1'b0;
                addressed     <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
                scl_drive_reg    <= 1'b0;
                stretch_wait_reg <= 1'b0;
                stretch_cnt_reg  <= '0;
`endif
            end else begin
`ifdef I2C_SLAVE_STRETCH_EN
                if (stretch_cnt_reg != 3'd0) begin
                    stretch_cnt_reg <= stretch_cnt_reg - 3'd1;
                    if (stretch_cnt_reg == 3'd1) begin
                        scl_drive_reg <= 1'b0;
                    end
                end
`endif
                if (receiving && scl_rise && (bc_reg != BITS_PER_BYTE)) begin
                    shift_reg <= {shift_reg[6:0], sda_level};
                    bc_reg    <= bc_reg + 4'd1;
                end
                if (receiving && byte_done) begin
                    bc_reg <= '0;
                end

                case (state_reg)
                    ST_ADDR: begin
                        if (byte_done) begin
                            if (addr_match(shift_reg, DEV_ADDR)) begin
                                sda_drive_reg <= 1'b1;
                                addressed     <= 1'b1;
                                rw_reg        <= shift_reg[0];
                                state_reg     <= ST_ADDR_ACK;
                                if (shift_reg[0]) begin
                                    rd_strobe <= 1'b1;
                                    rd_addr   <= ptr_reg;
                                end
                            end else begin
                                state_reg <= ST_IGNORE;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            sda_drive_reg <= 1'b0;
                            if (!rw_reg) begin
                                state_reg <= ST_PTR;
                            end else begin
                                state_reg <= ST_RDATA;
`ifdef I2C_SLAVE_STRETCH_EN
                                scl_drive_reg    <= 1'b1;
                                stretch_wait_reg <= 1'b1;
                                bc_reg           <= '0;
`else
                                shift_reg     <= rd_data;
                                sda_drive_reg <= ~rd_data[7];
                                bc_reg        <= 4'd1;
`endif
                            end
                        end
                    end
                    ST_PTR: begin
                        if (byte_done) begin
                            ptr_reg       <= shift_reg;
                            sda_drive_reg <= 1'b1;
                            state_reg     <= ST_PTR_ACK;
                        end
                    end
                    ST_PTR_ACK, ST_WDATA_ACK: begin
                        if (scl_fall) begin
                            sda_drive_reg <= 1'b0;
                            state_reg     <= ST_WDATA;
                        end
                    end
                    ST_WDATA: begin
                        if (byte_done) begin
                            wr_strobe     <= 1'b1;
                            wr_addr       <= ptr_reg;
                            wr_data       <= shift_reg;
                            ptr_reg       <= ptr_reg + 8'd1;
                            sda_drive_reg <= 1'b1;
                            state_reg     <= ST_WDATA_ACK;
                        end
                    end
                    ST_RDATA: begin
`ifdef I2C_SLAVE_STRETCH_EN
                        if (stretch_wait_reg) begin
                            if (rd_valid) begin
                                shift_reg        <= rd_data;
                                sda_drive_reg    <= ~rd_data[7];
                                bc_reg           <= 4'd1;
                                stretch_wait_reg <= 1'b0;
                                stretch_cnt_reg  <= STRETCH_RELEASE_CLKS;
                            end
                        end else
`endif
                        if (scl_fall) begin
                            if (bc_reg == BITS_PER_BYTE) begin
                                sda_drive_reg <= 1'b0;
                                got_ack_reg   <= 1'b0;
                                bc_reg        <= '0;
                                state_reg     <= ST_MACK;
                            end else begin
                                shift_reg     <= {shift_reg[6:0], 1'b0};
                                sda_drive_reg <= ~shift_reg[6];
                                bc_reg        <= bc_reg + 4'd1;
                            end
                        end
                    end
                    ST_MACK: begin
                        // Sample the master's ACK on the rise, fetch the next byte on the following fall
                        if (scl_rise && !got_ack_reg) begin
                            if (!sda_level) begin
                                ptr_reg     <= ptr_reg + 8'd1;
                                rd_strobe   <= 1'b1;
                                rd_addr     <= ptr_reg + 8'd1;
                                got_ack_reg <= 1'b1;
                            end else begin
                                state_reg <= ST_IGNORE;
                            end
                        end else if (scl_fall && got_ack_reg) begin
                            got_ack_reg <= 1'b0;
                            state_reg   <= ST_RDATA;
`ifdef I2C_SLAVE_STRETCH_EN
                            scl_drive_reg    <= 1'b1;
                            stretch_wait_reg <= 1'b1;
`else
                            shift_reg     <= rd_data;
                            sda_drive_reg <= ~rd_data[7];
                            bc_reg        <= 4'd1;
`endif
                        end
                    end
                    ST_IDLE, ST_IGNORE: begin
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign sda = sda_drive_reg ? 1'b0 : 1'bz;
`ifdef I2C_SLAVE_STRETCH_EN
    assign scl = scl_drive_reg ? 1'b0 : 1'bz;
`else
    assign scl = 1'bz;
`endif

endmodule

// File: tb/tb_i2c_slave_regif.sv
// Bench for i2c_slave_regif: bit-banged I2C master, strobe scoreboard and a pointer model.
module tb_i2c_slave_regif;

    localparam int         Q        = 5;
    localparam int         RD_DELAY = 250;
    localparam logic [6:0] DEV      = 7'h48;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    wire  scl;
    wire  sda;
    logic m_scl_low = 1'b0;
    logic m_sda_low = 1'b0;

    logic       wr_strobe;
    logic       rd_strobe;
    logic       addressed;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_addr;
    wire  [7:0] rd_data;
    wire        rd_valid;

    int checks      = 0;
    int failures    = 0;
    int max_stretch = 0;
    int rv_cnt      = 0;

    logic [15:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic [7:0]  model_ptr = 8'h00;

    pullup (scl);
    pullup (sda);
    assign scl = m_scl_low ? 1'b0 : 1'bz;
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    // User register bank returns the bitwise complement of the address
    assign rd_data  = rd_addr ^ 8'hFF;
    assign rd_valid = (rv_cnt == 0);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_strobe) rv_cnt <= RD_DELAY;
        else if (rv_cnt > 0) rv_cnt <= rv_cnt - 1;
    end

    i2c_slave_regif #(
        .DEV_ADDR    (DEV),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .scl       (scl),
        .sda       (sda),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_strobe (rd_strobe),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .addressed (addressed)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every strobe must match the oldest expected event
    always @(negedge clk) begin
        logic [15:0] e16;
        logic [7:0]  e8;
        if (!reset) begin
            if (wr_strobe) begin
                check("wr_strobe_exclusive", {15'd0, rd_strobe}, 16'd0);
                if (exp_wr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wr_unexpected actual=%h/%h required=no_strobe", wr_addr, wr_data);
                end else begin
                    e16 = exp_wr.pop_front();
                    check("wr_addr_data", {wr_addr, wr_data}, e16);
                end
            end
            if (rd_strobe) begin
                if (exp_rd.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rd_unexpected actual=%h required=no_strobe", rd_addr);
                end else begin
                    e8 = exp_rd.pop_front();
                    check("rd_addr", {8'd0, rd_addr}, {8'd0, e8});
                end
            end
        end
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic wq(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic wait_scl_high();
        int n;
        n = 0;
        #1;
        while (scl !== 1'b1 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        if (n > max_stretch) max_stretch = n;
        if (n >= 1000) begin
            checks++;
            failures++;
            $display("FAIL scl_release_timeout actual=low required=high");
        end
    endtask

    task automatic bus_start();
        m_sda_low = 1'b0;
        wq(Q);
        m_scl_low = 1'b0;
        wait_scl_high();
        wq(Q);
        m_sda_low = 1'b1;
        wq(Q);
        m_scl_low = 1'b1;
        wq(Q);
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1;
        wq(Q);
        m_scl_low = 1'b0;
        wait_scl_high();
        wq(Q);
        m_sda_low = 1'b0;
        wq(2 * Q);
    endtask

    task automatic write_bit(input logic b);
        m_sda_low = !b;
        wq(Q);
        m_scl_low = 1'b0;
        wait_scl_high();
        wq(2 * Q);
        m_scl_low = 1'b1;
        wq(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda_low = 1'b0;
        wq(Q);
        m_scl_low = 1'b0;
        wait_scl_high();
        wq(Q);
        b = sda;
        wq(Q);
        m_scl_low = 1'b1;
        wq(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(s);
        ack = !s;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic s;
        logic [7:0] t;
        t = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            read_bit(s);
            t[i] = s;
        end
        write_bit(!ack);
        d = t;
    endtask

    // addr+W, pointer, n data bytes, STOP; non-matching address stops after the NACK
    task automatic do_write(input logic [6:0] dev, input logic [7:0] p, input int n, input logic [31:0] d);
        logic       ack;
        logic       match;
        logic [7:0] b;
        match = (dev == DEV);
        $display("txn write dev=%h ptr=%h n=%0d data=%h", dev, p, n, d);
        bus_start();
        write_byte({dev, 1'b0}, ack);
        check("addr_ack", {15'd0, ack}, {15'd0, match});
        check("addressed_after_addr", {15'd0, addressed}, {15'd0, match});
        if (match) begin
            write_byte(p, ack);
            check("ptr_ack", {15'd0, ack}, 16'd1);
            model_ptr = p;
            for (int i = 0; i < n; i++) begin
                b = d[31 - 8 * i -: 8];
                exp_wr.push_back({model_ptr, b});
                write_byte(b, ack);
                check("wdata_ack", {15'd0, ack}, 16'd1);
                model_ptr = model_ptr + 8'd1;
            end
        end
        bus_stop();
        check("addressed_after_stop", {15'd0, addressed}, 16'd0);
    endtask

    // Optional pointer write + repeated START, then addr+R and n bytes, last one NACKed
    task automatic do_read(input logic set_ptr, input logic [7:0] p, input int n);
        logic       ack;
        logic [7:0] d;
        logic [7:0] a;
        $display("txn read set_ptr=%0d ptr=%h n=%0d", set_ptr, set_ptr ? p : model_ptr, n);
        bus_start();
        if (set_ptr) begin
            write_byte({DEV, 1'b0}, ack);
            check("rd_wr_addr_ack", {15'd0, ack}, 16'd1);
            write_byte(p, ack);
            check("rd_ptr_ack", {15'd0, ack}, 16'd1);
            model_ptr = p;
            bus_start();
        end
        for (int i = 0; i < n; i++) begin
            a = model_ptr + 8'(i);
            exp_rd.push_back(a);
        end
        write_byte({DEV, 1'b1}, ack);
        check("rd_addr_ack", {15'd0, ack}, 16'd1);
        check("addressed_in_read", {15'd0, addressed}, 16'd1);
        for (int i = 0; i < n; i++) begin
            read_byte(d, i != n - 1);
            a = model_ptr + 8'(i);
            check("rd_byte", {8'd0, d}, {8'd0, a ^ 8'hFF});
        end
        model_ptr = model_ptr + 8'(n - 1);
        bus_stop();
        check("addressed_after_rd_stop", {15'd0, addressed}, 16'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("sda_released_on_reset", {15'd0, sda}, 16'd1);
        check("addressed_on_reset", {15'd0, addressed}, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        model_ptr = 8'h00;
        m_sda_low = 1'b0;
        m_scl_low = 1'b0;
        wq(4 * Q);
    endtask

    initial begin
        int          kind;
        int          n;
        logic        ack;
        logic [6:0]  dev;
        logic [7:0]  addr_w;

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_wr_strobe", {15'd0, wr_strobe}, 16'd0);
        check("rst_rd_strobe", {15'd0, rd_strobe}, 16'd0);
        check("rst_wr_addr", {8'd0, wr_addr}, 16'd0);
        check("rst_wr_data", {8'd0, wr_data}, 16'd0);
        check("rst_rd_addr", {8'd0, rd_addr}, 16'd0);
        check("rst_addressed", {15'd0, addressed}, 16'd0);
        check("rst_sda", {15'd0, sda}, 16'd1);
        check("rst_scl", {15'd0, scl}, 16'd1);
        reset = 1'b0;
        wq(4 * Q);

        do_write(DEV, 8'h05, 2, 32'hA53C_0000);
        do_read(1'b1, 8'h10, 3);
        do_write(7'h22, 8'h00, 1, 32'h5500_0000);
        do_write(DEV, 8'hFF, 2, $urandom());

        $display("txn reset mid WDATA bit 4");
        bus_start();
        write_byte({DEV, 1'b0}, ack);
        check("rst_wd_addr_ack", {15'd0, ack}, 16'd1);
        write_byte(8'h30, ack);
        check("rst_wd_ptr_ack", {15'd0, ack}, 16'd1);
        for (int i = 0; i < 4; i++) write_bit(1'b1);
        pulse_reset();
        do_write(DEV, 8'h40, 2, 32'h1122_0000);

        $display("txn reset during address ACK");
        bus_start();
        addr_w = {DEV, 1'b0};
        for (int i = 7; i >= 0; i--) write_bit(addr_w[i]);
        m_sda_low = 1'b0;
        wq(Q);
        check("ack_driven_before_reset", {15'd0, sda}, 16'd0);
        pulse_reset();
        do_read(1'b0, 8'h00, 2);

        for (int t = 0; t < 10; t++) begin
            kind = $urandom_range(0, 3);
            n    = $urandom_range(1, 4);
            case (kind)
                0: do_write(DEV, 8'($urandom()), n, $urandom());
                1: do_read(1'b1, 8'($urandom()), n);
                2: do_read(1'b0, 8'h00, n);
                default: begin
                    dev = 7'($urandom_range(0, 127));
                    if (dev == DEV) dev = 7'h22;
                    do_write(dev, 8'($urandom()), n, $urandom());
                end
            endcase
        end

        wq(4 * Q);
        check("wr_queue_drained", 16'(exp_wr.size()), 16'd0);
        check("rd_queue_drained", 16'(exp_rd.size()), 16'd0);
`ifdef I2C_SLAVE_STRETCH_EN
        check("scl_stretch_seen", {15'd0, max_stretch >= 200}, 16'd1);
`else
        check("scl_never_stretched", 16'(max_stretch), 16'd0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
